// File: rtl/shifter_pkg.sv
// Shared types and constants for the multicycle shifter: FSM states,
// datapath widths and the per-stage shift amounts.
package shifter_pkg;

  localparam int DATA_W     = 32;
  localparam int SHAMT_W    = 5;
  localparam int NUM_STAGES = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Stage k shifts by 2**(4-k), so stage k pairs with shamt bit 4-k.
  localparam logic [SHAMT_W-1:0] STAGE_AMT [NUM_STAGES] = '{
    5'd16, 5'd8, 5'd4, 5'd2, 5'd1
  };

  function automatic logic [SHAMT_W-1:0] stage_amount(input logic [2:0] k);
    logic [SHAMT_W-1:0] amt;
    case (k)
      3'd0:    amt = STAGE_AMT[0];
      3'd1:    amt = STAGE_AMT[1];
      3'd2:    amt = STAGE_AMT[2];
      3'd3:    amt = STAGE_AMT[3];
      3'd4:    amt = STAGE_AMT[4];
      default: amt = '0;
    endcase
    return amt;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational shift step: when enabled, shifts by the given amount.
// The arithmetic-right path exists only with MULTICYCLE_SHIFTER_SRA_EN defined.
module shift_stage
  import shifter_pkg::*;
(
  input  logic [DATA_W-1:0]  data_in,
  input  logic [SHAMT_W-1:0] amount,
  input  logic               enable,
  input  logic               sra,
  output logic [DATA_W-1:0]  data_out
);

`ifdef MULTICYCLE_SHIFTER_SRA_EN
  always_comb begin
    data_out = data_in;
    if (enable) begin
      if (sra) begin
        data_out = $unsigned($signed(data_in) >>> amount);
      end else begin
        data_out = data_in << amount;
      end
    end
  end
`else
  logic unused_sra;
  assign unused_sra = sra;

  always_comb begin
    data_out = data_in;
    if (enable) begin
      data_out = data_in << amount;
    end
  end
`endif

endmodule

// File: rtl/multicycle_shifter.sv
// Five-cycle 32-bit shifter (16/8/4/2/1 stages) with IDLE/SHIFT/DONE control.
// Optional arithmetic right shift enabled by macro MULTICYCLE_SHIFTER_SRA_EN.
module multicycle_shifter
  import shifter_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               ctrl_start,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               ctrl_sra,
  output logic [DATA_W-1:0]  data_result,
  output logic               data_resultRDY,
  output logic               busy
);

  state_t             state_reg, state_next;
  logic [DATA_W-1:0]  work_reg, work_next;
  logic [DATA_W-1:0]  result_reg, result_next;
  logic [SHAMT_W-1:0] shamt_reg, shamt_next;
  logic [2:0]         stage_reg, stage_next;
  logic               sra_dir;
  logic               accept;
  logic               last_stage;
  logic [DATA_W-1:0]  stage_out;

`ifdef MULTICYCLE_SHIFTER_SRA_EN
  logic sra_reg, sra_next;
  assign sra_dir = sra_reg;
`else
  logic unused_ctrl_sra;
  assign unused_ctrl_sra = ctrl_sra;
  assign sra_dir         = 1'b0;
`endif

  assign accept     = ctrl_start && (state_reg == IDLE || state_reg == DONE);
  assign last_stage = (stage_reg == 3'(NUM_STAGES - 1));

  // shamt_reg is shifted left every stage, so its MSB is always the bit for the current stage.
  shift_stage u_stage (
    .data_in  (work_reg),
    .amount   (stage_amount(stage_reg)),
    .enable   (shamt_reg[SHAMT_W-1]),
    .sra      (sra_dir),
    .data_out (stage_out)
  );

  always_comb begin
    state_next  = state_reg;
    work_next   = work_reg;
    result_next = result_reg;
    shamt_next  = shamt_reg;
    stage_next  = stage_reg;
`ifdef MULTICYCLE_SHIFTER_SRA_EN
    sra_next    = sra_reg;
`endif
    case (state_reg)
      SHIFT: begin
        work_next  = stage_out;
        shamt_next = shamt_reg << 1;
        stage_next = stage_reg + 3'd1;
        if (last_stage) begin
          result_next = stage_out;
          state_next  = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // A start is only seen in IDLE/DONE; it overrides the default transition out of those states.
    if (accept) begin
      work_next  = data_in;
      shamt_next = shamt;
      stage_next = 3'd0;
      state_next = SHIFT;
`ifdef MULTICYCLE_SHIFTER_SRA_EN
      sra_next   = ctrl_sra;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      work_reg   <= '0;
      result_reg <= '0;
      shamt_reg  <= '0;
      stage_reg  <= '0;
`ifdef MULTICYCLE_SHIFTER_SRA_EN
      sra_reg    <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      work_reg   <= work_next;
      result_reg <= result_next;
      shamt_reg  <= shamt_next;
      stage_reg  <= stage_next;
`ifdef MULTICYCLE_SHIFTER_SRA_EN
      sra_reg    <= sra_next;
`endif
    end
  end

  assign data_result    = result_reg;
  assign data_resultRDY = (state_reg == DONE);
  assign busy           = (state_reg == SHIFT);

endmodule

// File: tb/tb_multicycle_shifter.sv
// Self-checking bench for multicycle_shifter: directed corner cases plus
// randomized operations against an arithmetic reference model.
module tb_multicycle_shifter;
  import shifter_pkg::*;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              ctrl_start = 1'b0;
  logic [31:0]       data_in = '0;
  logic [4:0]        shamt = '0;
  logic              ctrl_sra = 1'b0;
  logic [31:0]       data_result;
  logic              data_resultRDY;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] held_res = '0;

  multicycle_shifter dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_start     (ctrl_start),
    .data_in        (data_in),
    .shamt          (shamt),
    .ctrl_sra       (ctrl_sra),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the whole shift amount.
  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s, input logic sra);
    longint v;
`ifdef MULTICYCLE_SHIFTER_SRA_EN
    if (sra) begin
      v = longint'($signed(d));
      return 32'(v / (longint'(1) << s) - ((v < 0 && (v % (longint'(1) << s)) != 0) ? 1 : 0));
    end
`endif
    v = longint'(d) * (longint'(1) << s);
    return v[31:0];
  endfunction

  // Called #1 after a rising edge (or mid-cycle); issues one op and follows it into DONE.
  task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] s,
                        input logic sra, input bit mid_start);
    logic [31:0] exp;
    exp = model(d, s, sra);
    data_in = d; shamt = s; ctrl_sra = sra; ctrl_start = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clock); #1;
      ctrl_start = 1'b0;
      data_in = $urandom; shamt = 5'($urandom); ctrl_sra = 1'($urandom);
      if (mid_start && e == 3) ctrl_start = 1'b1;
      if (e < 6) begin
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        check({tag, "_rdy_early"}, {31'b0, data_resultRDY}, 32'd0);
        check({tag, "_held"}, data_result, held_res);
      end else begin
        check({tag, "_rdy"}, {31'b0, data_resultRDY}, 32'd1);
        check({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
        check({tag, "_res"}, data_result, exp);
      end
    end
    held_res = exp;
    $display("op %s d=0x%08h s=%0d sra=%0d -> 0x%08h (exp 0x%08h)", tag, d, s, sra, data_result, exp);
  endtask

  task automatic idle_cycle(input string tag);
    ctrl_start = 1'b0;
    @(posedge clock); #1;
    check({tag, "_rdy_off"}, {31'b0, data_resultRDY}, 32'd0);
    check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_res_stable"}, data_result, held_res);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("reset_res", data_result, 32'd0);
    check("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    // Start set up before the first rising edge after release must be taken.
    run_op("first_after_reset", 32'h0000_0001, 5'd31, 1'b0, 1'b0);
    idle_cycle("first_after_reset");
    run_op("sra_neg", 32'h8000_0000, 5'd4, 1'b1, 1'b0);
    idle_cycle("sra_neg");
    run_op("sra_pos", 32'h7FFF_FFF0, 5'd4, 1'b1, 1'b0);
    idle_cycle("sra_pos");
    run_op("zero_shift", 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0);
    idle_cycle("zero_shift");
    run_op("ignored_start", 32'h1234_5678, 5'd5, 1'b0, 1'b1);
    idle_cycle("ignored_start");
    idle_cycle("ignored_start_tail");

    // Reset in cycle 2 of an operation.
    data_in = 32'hFFFF_0001; shamt = 5'd3; ctrl_sra = 1'b0; ctrl_start = 1'b1;
    @(posedge clock); #1; ctrl_start = 1'b0;
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    check("midrst_res", data_result, 32'd0);
    check("midrst_rdy", {31'b0, data_resultRDY}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    held_res = '0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      check("midrst_no_rdy", {31'b0, data_resultRDY}, 32'd0);
      check("midrst_res_zero", data_result, 32'd0);
    end

    // Back-to-back: second start issued during DONE.
    run_op("b2b_a", 32'hCAFE_F00D, 5'd7, 1'b1, 1'b0);
    run_op("b2b_b", 32'h0F0F_0F0F, 5'd17, 1'b0, 1'b0);
    idle_cycle("b2b_b");

    for (int i = 0; i < 40; i++) begin
      logic [31:0] d;
      logic [4:0]  s;
      logic        r;
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      r = 1'($urandom);
      run_op($sformatf("rnd%0d", i), d, s, r, 1'($urandom));
      if ($urandom_range(0, 1) == 0) idle_cycle($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_shifter.md
MULTICYCLE_SHIFTER -- requirements
Module: multicycle_shifter

Interface
REQ-001 Parameters: none; data width is fixed at 32 bits and shift amount at 5 bits.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 ctrl_start  input  1  request to begin a shift; sampled on the rising clock edge.
REQ-005 data_in  input  32  operand; captured when a start is accepted.
REQ-006 shamt  input  5  shift amount 0..31; captured when a start is accepted.
REQ-007 ctrl_sra  input  1  1=arithmetic right shift, 0=logical left shift; captured with the operands.
REQ-008 data_result  output  32  shift result; held stable from DONE until the next accepted start.
REQ-009 data_resultRDY  output  1  one-cycle pulse; result is valid in that cycle.
REQ-010 busy  output  1  high while in SHIFT.

Function
REQ-011 FSM states: IDLE, SHIFT, DONE.
REQ-012 A start is accepted only in IDLE or DONE; ctrl_start during SHIFT shall be ignored with no queueing.
REQ-013 On an accepted start, latch data_in, shamt and ctrl_sra, clear the 3-bit stage counter, and enter SHIFT.
REQ-014 SHIFT runs exactly 5 cycles, stage k=0..4 applying a shift of 16, 8, 4, 2, 1 respectively.
REQ-015 A stage shifts the working register only when its latched shamt bit (bit 4-k) is 1; otherwise the register holds.
REQ-016 Left shift fills vacated LSBs with 0.
REQ-017 Arithmetic right shift fills vacated MSBs with a copy of bit 31 of the working register.
REQ-018 After stage 4, enter DONE: data_resultRDY=1 for exactly that one cycle, and busy=0.
REQ-019 Latency is fixed: start sampled at the end of cycle 0, DONE in cycle 6, independent of shamt, including shamt=0.
REQ-020 From DONE: enter SHIFT if ctrl_start=1 (back-to-back operation), otherwise enter IDLE.
REQ-021 data_result shall always reflect the last completed operation and is updated only on entry to DONE.

Reset
REQ-022 Asserting reset_n low immediately forces IDLE, with data_result=0, data_resultRDY=0 and busy=0.
REQ-023 Reset mid-operation aborts the operation with no RDY pulse.
REQ-024 A start is honoured on the first rising edge after reset_n deasserts.

Configuration
REQ-025 With macro MULTICYCLE_SHIFTER_SRA_EN defined, ctrl_sra selects the direction as in REQ-007.
REQ-026 Without the macro, ctrl_sra shall be ignored and every operation is a logical left shift; the right-shift datapath is not synthesised.

Structure
REQ-027 Package shifter_pkg holds the FSM state enum, DATA_W=32, SHAMT_W=5 and the stage-amount constant table {16,8,4,2,1}.
REQ-028 One combinational sub-module, shift_stage, applies a single enabled, direction-selectable shift by an amount given per stage; it is instantiated once and driven by the stage counter.

Verification
REQ-029 Left shift: data_in=0x00000001, shamt=31, ctrl_sra=0 -> data_result=0x80000000 with RDY in cycle 6.
REQ-030 Arithmetic right shift, negative operand (SRA_EN defined): data_in=0x80000000, shamt=4, ctrl_sra=1 -> 0xF8000000.
REQ-031 Arithmetic right shift, positive operand: data_in=0x7FFFFFF0, shamt=4, ctrl_sra=1 -> 0x07FFFFFF.
REQ-032 Zero shift: shamt=0, data_in=0xDEADBEEF -> 0xDEADBEEF with RDY still in cycle 6.
REQ-033 Start during SHIFT: a second start in cycle 3 -> ignored, exactly one RDY pulse, with the first operation's result.
REQ-034 Reset mid-operation and back-to-back: reset_n low in cycle 2 -> no RDY and outputs zero; start asserted in DONE -> next RDY exactly 6 cycles later.
